farm_sensor_cond: RTL and testbench

- Conditions the raw farm-road loop-detector signal into the registered `sen` input consumed by the traffic light controller.
- Synchronises the asynchronous detector and debounces both arrival and departure.
- Counts vehicle arrivals.
- Detects a stuck-on detector and fails safe, so the highway is never starved by a permanent farm-road green.

---
 rtl/traffic_pkg.sv | 19 +
 rtl/sync_2ff.sv | 26 ++
 rtl/farm_sensor_cond.sv | 160 ++++++++++++++++
 tb/tb_farm_sensor_cond.sv | 171 +++++++++++++++++
 4 files changed

// File: rtl/traffic_pkg.sv
// traffic_pkg: definitions shared by the farm-road sensor conditioner and the
// traffic light controller.
//   sensor_state_t : 3-bit encoding of the sensor conditioner FSM
//   SEN_CLEAR      : value of `sen` when the farm road is clear
//   SEN_PRESENT    : value of `sen` when a vehicle is waiting/present
package traffic_pkg;

  typedef enum logic [2:0] {
    S_CLEAR     = 3'd0,
    S_ARRIVING  = 3'd1,
    S_PRESENT   = 3'd2,
    S_DEPARTING = 3'd3,
    S_FAULT     = 3'd4
  } sensor_state_t;

  localparam logic SEN_CLEAR   = 1'b1;
  localparam logic SEN_PRESENT = 1'b0;

endpackage

// File: rtl/sync_2ff.sv
// sync_2ff: two-flop synchroniser for a single asynchronous input.
// Ports:
//   clk   in  destination clock
//   reset in  asynchronous, active-low; clears both flops to 0
//   d     in  asynchronous input
//   q     out synchronised copy of d, two clk edges of latency
module sync_2ff (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic s1;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s1 <= 1'b0;
      q  <= 1'b0;
    end else begin
      s1 <= d;
      q  <= s1;
    end
  end

endmodule

// File: rtl/farm_sensor_cond.sv
// farm_sensor_cond: conditions the raw farm-road loop detector into the
// registered `sen` input of the traffic light controller. The detector is
// synchronised, arrival and departure are debounced, arrivals are counted,
// and a detector stuck on for too long forces `sen` back to clear so the
// highway is never starved.
// Ports:
//   clk         in  system clock (rising edge)
//   reset       in  asynchronous, active-low
//   det_raw     in  raw loop detector, 1 = vehicle over loop (async)
//   clr_count   in  synchronous clear of the arrivals counter
//   sen         out 1 = farm road clear, 0 = vehicle waiting/present
//   veh_present out 1 while a vehicle is present or departing
//   stuck_fault out 1 while the detector is considered stuck
//   arrivals    out saturating count of debounced arrivals
module farm_sensor_cond
  import traffic_pkg::*;
#(
  parameter int DEBOUNCE    = 4,
  parameter int STUCK_LIMIT = 255,
  parameter int CNT_W       = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             det_raw,
  input  logic             clr_count,
  output logic             sen,
  output logic             veh_present,
  output logic             stuck_fault,
  output logic [CNT_W-1:0] arrivals
);

  localparam int TMR_W = $clog2(STUCK_LIMIT + 1);
  localparam logic [3:0]       DEB_LAST = 4'(DEBOUNCE - 1);
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(STUCK_LIMIT - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  logic             det_s;
  sensor_state_t    state, state_nxt;
  logic [3:0]       deb_cnt, deb_nxt;
  logic [TMR_W-1:0] stuck_tmr, tmr_nxt;
  logic             count_inc;
  logic             sen_nxt, veh_nxt, fault_nxt;

  sync_2ff u_sync (
    .clk   (clk),
    .reset (reset),
    .d     (det_raw),
    .q     (det_s)
  );

  // Outputs are decoded from the next state and registered alongside it, so
  // they change on the same edge as the state with no combinational path out.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= S_CLEAR;
      deb_cnt     <= '0;
      stuck_tmr   <= '0;
      sen         <= SEN_CLEAR;
      veh_present <= 1'b0;
      stuck_fault <= 1'b0;
      arrivals    <= '0;
    end else begin
      state       <= state_nxt;
      deb_cnt     <= deb_nxt;
      stuck_tmr   <= tmr_nxt;
      sen         <= sen_nxt;
      veh_present <= veh_nxt;
      stuck_fault <= fault_nxt;
      if (clr_count) begin
        arrivals <= '0;
      end else if (count_inc && (arrivals != CNT_MAX)) begin
        arrivals <= arrivals + CNT_W'(1);
      end
    end
  end

  // Both counters compare against their last value before incrementing, so
  // neither can wrap. A return from DEPARTING to PRESENT keeps stuck_tmr so a
  // bouncing stuck detector still reaches FAULT.
  always_comb begin
    state_nxt = state;
    deb_nxt   = deb_cnt;
    tmr_nxt   = stuck_tmr;
    count_inc = 1'b0;
    case (state)
      S_CLEAR: begin
        if (det_s) begin
          state_nxt = S_ARRIVING;
          deb_nxt   = 4'd1;
        end
      end
      S_ARRIVING: begin
        if (!det_s) begin
          state_nxt = S_CLEAR;
          deb_nxt   = 4'd0;
        end else if (deb_cnt == DEB_LAST) begin
          state_nxt = S_PRESENT;
          tmr_nxt   = '0;
          count_inc = 1'b1;
        end else begin
          deb_nxt = deb_cnt + 4'd1;
        end
      end
      S_PRESENT: begin
        if (!det_s) begin
          state_nxt = S_DEPARTING;
          deb_nxt   = 4'd1;
        end else if (stuck_tmr == TMR_LAST) begin
          state_nxt = S_FAULT;
          deb_nxt   = 4'd0;
        end else begin
          tmr_nxt = stuck_tmr + TMR_W'(1);
        end
      end
      S_DEPARTING: begin
        if (det_s) begin
          state_nxt = S_PRESENT;
        end else if (deb_cnt == DEB_LAST) begin
          state_nxt = S_CLEAR;
        end else begin
          deb_nxt = deb_cnt + 4'd1;
        end
      end
      S_FAULT: begin
        if (det_s) begin
          deb_nxt = 4'd0;
        end else if (deb_cnt == DEB_LAST) begin
          state_nxt = S_CLEAR;
        end else begin
          deb_nxt = deb_cnt + 4'd1;
        end
      end
      default: begin
        state_nxt = S_CLEAR;
        deb_nxt   = 4'd0;
        tmr_nxt   = '0;
      end
    endcase
  end

  // FAULT deliberately reports the road as clear to hand priority back to
  // the highway.
  always_comb begin
    sen_nxt   = SEN_CLEAR;
    veh_nxt   = 1'b0;
    fault_nxt = 1'b0;
    case (state_nxt)
      S_PRESENT, S_DEPARTING: begin
        sen_nxt = SEN_PRESENT;
        veh_nxt = 1'b1;
      end
      S_FAULT: begin
        fault_nxt = 1'b1;
      end
      default: begin
      end
    endcase
  end

endmodule

// File: tb/tb_farm_sensor_cond.sv
// tb_farm_sensor_cond: directed, table-driven bench for farm_sensor_cond with
// DEBOUNCE=4, STUCK_LIMIT=16, CNT_W=2. Inputs change on the falling edge and
// outputs are compared on the falling edge after each rising edge.
module tb_farm_sensor_cond;

  logic       clk;
  logic       reset;
  logic       det_raw;
  logic       clr_count;
  logic       sen;
  logic       veh_present;
  logic       stuck_fault;
  logic [1:0] arrivals;

  int compared   = 0;
  int mismatched = 0;

  typedef struct {
    logic       det;
    logic       clr;
    logic       sen;
    logic       veh;
    logic       fault;
    logic [1:0] arr;
    string      name;
  } vec_t;

  vec_t vecs[$];

  farm_sensor_cond #(
    .DEBOUNCE    (4),
    .STUCK_LIMIT (16),
    .CNT_W       (2)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .det_raw     (det_raw),
    .clr_count   (clr_count),
    .sen         (sen),
    .veh_present (veh_present),
    .stuck_fault (stuck_fault),
    .arrivals    (arrivals)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic add_vec(input int n, input logic det, input logic clr,
                         input logic e_sen, input logic e_veh,
                         input logic e_fault, input logic [1:0] e_arr,
                         input string name);
    vec_t v;
    v.det = det; v.clr = clr; v.sen = e_sen; v.veh = e_veh;
    v.fault = e_fault; v.arr = e_arr; v.name = name;
    for (int i = 0; i < n; i++) vecs.push_back(v);
  endtask

  // One rising edge with the given inputs; returns on the following falling edge.
  task automatic apply_stimulus(input logic det, input logic clr);
    det_raw   = det;
    clr_count = clr;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic check_output(input string name, input logic e_sen,
                              input logic e_veh, input logic e_fault,
                              input logic [1:0] e_arr);
    compared++;
    if ({sen, veh_present, stuck_fault, arrivals} !== {e_sen, e_veh, e_fault, e_arr}) begin
      mismatched++;
      $display("[TB] FAIL %s: got sen=%0b veh=%0b fault=%0b arr=%0d, want sen=%0b veh=%0b fault=%0b arr=%0d",
               name, sen, veh_present, stuck_fault, arrivals, e_sen, e_veh, e_fault, e_arr);
    end
  endtask

  // Full arrival (edge 6) followed by full departure (edge 6 after the drop).
  task automatic arrive_and_leave(input logic [1:0] e_arr, input string name);
    for (int i = 0; i < 6; i++) apply_stimulus(1'b1, 1'b0);
    check_output(name, 1'b0, 1'b1, 1'b0, e_arr);
    for (int i = 0; i < 6; i++) apply_stimulus(1'b0, 1'b0);
    check_output({name, "_left"}, 1'b1, 1'b0, 1'b0, e_arr);
  endtask

  initial begin
    reset     = 1'b0;
    det_raw   = 1'b0;
    clr_count = 1'b0;

    // Glitch: 3 high edges never get through the debounce.
    add_vec(3, 1, 0, 1, 0, 0, 2'd0, "glitch_hi");
    add_vec(4, 0, 0, 1, 0, 0, 2'd0, "glitch_lo");
    // Clean arrival: sen falls at edge 6.
    add_vec(5, 1, 0, 1, 0, 0, 2'd0, "arrive_wait");
    add_vec(1, 1, 0, 0, 1, 0, 2'd1, "arrive_edge6");
    add_vec(2, 1, 0, 0, 1, 0, 2'd1, "present_hold");
    // Departure bounce: 2 low edges, then back high.
    add_vec(2, 0, 0, 0, 1, 0, 2'd1, "bounce_lo");
    add_vec(4, 1, 0, 0, 1, 0, 2'd1, "bounce_hi");
    // Real departure: sen rises at edge 6 after the drop.
    add_vec(5, 0, 0, 0, 1, 0, 2'd1, "depart_wait");
    add_vec(1, 0, 0, 1, 0, 0, 2'd1, "depart_edge6");
    add_vec(1, 0, 0, 1, 0, 0, 2'd1, "clear_hold");
    add_vec(1, 0, 1, 1, 0, 0, 2'd0, "clr_count");
    add_vec(1, 0, 0, 1, 0, 0, 2'd0, "idle");

    // Reset defaults, held and after release.
    repeat (2) @(negedge clk);
    check_output("reset_hold", 1'b1, 1'b0, 1'b0, 2'd0);
    reset = 1'b1;
    apply_stimulus(1'b0, 1'b0);
    apply_stimulus(1'b0, 1'b0);
    check_output("reset_release", 1'b1, 1'b0, 1'b0, 2'd0);

    foreach (vecs[i]) begin
      apply_stimulus(vecs[i].det, vecs[i].clr);
      check_output(vecs[i].name, vecs[i].sen, vecs[i].veh, vecs[i].fault, vecs[i].arr);
    end

    // Stuck detector: FAULT 16 edges after PRESENT, then 6 edges to recover.
    for (int i = 0; i < 5; i++) apply_stimulus(1'b1, 1'b0);
    check_output("stuck_pre", 1'b1, 1'b0, 1'b0, 2'd0);
    apply_stimulus(1'b1, 1'b0);
    check_output("stuck_arrive", 1'b0, 1'b1, 1'b0, 2'd1);
    for (int i = 0; i < 15; i++) apply_stimulus(1'b1, 1'b0);
    check_output("stuck_t15", 1'b0, 1'b1, 1'b0, 2'd1);
    apply_stimulus(1'b1, 1'b0);
    check_output("stuck_fault", 1'b1, 1'b0, 1'b1, 2'd1);
    apply_stimulus(1'b1, 1'b0);
    check_output("fault_held", 1'b1, 1'b0, 1'b1, 2'd1);
    for (int i = 0; i < 5; i++) apply_stimulus(1'b0, 1'b0);
    check_output("fault_wait", 1'b1, 1'b0, 1'b1, 2'd1);
    apply_stimulus(1'b0, 1'b0);
    check_output("fault_exit", 1'b1, 1'b0, 1'b0, 2'd1);

    // Counter saturation at 3 with CNT_W=2.
    apply_stimulus(1'b0, 1'b1);
    check_output("sat_clear", 1'b1, 1'b0, 1'b0, 2'd0);
    arrive_and_leave(2'd1, "sat_a1");
    arrive_and_leave(2'd2, "sat_a2");
    arrive_and_leave(2'd3, "sat_a3");
    arrive_and_leave(2'd3, "sat_a4");

    // Async reset while PRESENT takes effect without a clock edge.
    for (int i = 0; i < 6; i++) apply_stimulus(1'b1, 1'b0);
    check_output("sat_a5_present", 1'b0, 1'b1, 1'b0, 2'd3);
    #2;
    reset = 1'b0;
    #1;
    check_output("reset_async", 1'b1, 1'b0, 1'b0, 2'd0);
    det_raw = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < 3; i++) apply_stimulus(1'b0, 1'b0);
    check_output("reset_recover", 1'b1, 1'b0, 1'b0, 2'd0);

    // clr_count beats the increment on the arrival edge.
    arrive_and_leave(2'd1, "pre_clr");
    for (int i = 0; i < 5; i++) apply_stimulus(1'b1, 1'b0);
    apply_stimulus(1'b1, 1'b1);
    check_output("clr_wins", 1'b0, 1'b1, 1'b0, 2'd0);
    apply_stimulus(1'b1, 1'b0);
    check_output("clr_hold", 1'b0, 1'b1, 1'b0, 2'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
